// File: rtl/store_buffer.sv
// store_buffer
//   Converts RV32I store requests from the MEM stage into word-aligned,
//   lane-replicated write data with byte enables. Entries wait in a small
//   circular FIFO that drains in program order to data memory over a
//   request/acknowledge handshake. Misaligned stores are dropped and
//   flagged. Loads are checked against pending entries so the hazard unit
//   can stall.
//
// Handshakes:
//   MEM side: a store is taken at a rising edge when st_valid & st_ready
//             and the request is a real, aligned store. st_ready never looks
//             at the memory side, so a full buffer refuses a store even when
//             the head pops in the same cycle.
//   Memory side: mem_wr_en requests a write of the head entry. mem_wr_ack
//             at an edge while mem_wr_en=1 pops the head. An ack while
//             mem_wr_en=0 is ignored.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   st_valid, st_type           store request and kind (SB/SH/SW/NOMEM)
//   st_addr, st_data            store byte address, rs2 value
//   st_ready                    buffer can take a store this cycle
//   st_misaligned               one-cycle pulse after a dropped misaligned store
//   mem_wr_en/addr/data/be      head entry write request toward memory
//   mem_wr_ack                  memory accepted the head write
//   ld_valid, ld_addr           load in MEM stage
//   ld_hit                      load word matches a pending entry
//   buf_empty                   no pending entries
module store_buffer #(
    parameter int         DEPTH    = 2,
    parameter logic [2:0] ST_SB    = 3'b000,
    parameter logic [2:0] ST_SH    = 3'b001,
    parameter logic [2:0] ST_SW    = 3'b010,
    parameter logic [2:0] ST_NOMEM = 3'b111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    input  logic [2:0]  st_type,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    output logic        st_misaligned,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_wr_be,
    input  logic        mem_wr_ack,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_hit,
    output logic        buf_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [3:0]    be_q   [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic        is_store;
    logic        bad_align;
    logic [31:0] new_data;
    logic [3:0]  new_be;
    logic        push;
    logic        pop;
    logic [DEPTH-1:0] live;

    // Byte offset within the word is irrelevant to the hazard check.
    logic unused_ld_lsbs;
    assign unused_ld_lsbs = ^ld_addr[1:0];

    // Entry formation: data is replicated across lanes so the memory only
    // needs the byte enables to pick the right bytes.
    always_comb begin
        is_store  = 1'b0;
        bad_align = 1'b0;
        new_data  = st_data;
        new_be    = 4'b0000;
        case (st_type)
            ST_SB: begin
                is_store = 1'b1;
                new_data = {4{st_data[7:0]}};
                new_be   = 4'b0001 << st_addr[1:0];
            end
            ST_SH: begin
                is_store  = 1'b1;
                bad_align = st_addr[0];
                new_data  = {2{st_data[15:0]}};
                new_be    = st_addr[1] ? 4'b1100 : 4'b0011;
            end
            ST_SW: begin
                is_store  = 1'b1;
                bad_align = |st_addr[1:0];
                new_data  = st_data;
                new_be    = 4'b1111;
            end
            ST_NOMEM: ;
            default: ;
        endcase
    end

    assign st_ready  = (count < CW'(DEPTH)) & ~rst;
    assign push      = st_valid & st_ready & is_store & ~bad_align;
    assign pop       = mem_wr_ack & mem_wr_en;

    assign mem_wr_en   = ~rst & (count != '0);
    assign mem_wr_addr = mem_wr_en ? addr_q[head] : 32'h0;
    assign mem_wr_data = mem_wr_en ? data_q[head] : 32'h0;
    assign mem_wr_be   = mem_wr_en ? be_q[head]   : 4'h0;
    assign buf_empty   = rst | (count == '0);

    // An entry is pending when its distance from head is below count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_live
        logic [PW-1:0] off;
        assign off     = PW'(g) - head;
        assign live[g] = ({1'b0, off} < count);
    end

    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && (addr_q[i][31:2] == ld_addr[31:2])) begin
                ld_hit = 1'b1;
            end
        end
        ld_hit = ld_hit & ld_valid & ~rst;
    end

    // Storage needs no reset: outputs and the hazard check are qualified
    // by count and liveness.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= {st_addr[31:2], 2'b00};
            data_q[tail] <= new_data;
            be_q[tail]   <= new_be;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            st_misaligned <= 1'b0;
        end else begin
            st_misaligned <= st_valid & st_ready & is_store & bad_align;
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
    localparam int DEPTH = 2;
    localparam logic [2:0] T_SB = 3'b000, T_SH = 3'b001, T_SW = 3'b010, T_NOMEM = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic [2:0]  st_type;
    logic [31:0] st_addr, st_data;
    logic        st_ready, st_misaligned;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr, mem_wr_data;
    logic [3:0]  mem_wr_be;
    logic        mem_wr_ack;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hit, buf_empty;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } entry_t;

    entry_t exp_q[$];
    logic   mis_exp;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_type(st_type), .st_addr(st_addr), .st_data(st_data),
        .st_ready(st_ready), .st_misaligned(st_misaligned),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_be(mem_wr_be), .mem_wr_ack(mem_wr_ack),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .buf_empty(buf_empty)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        st_valid   = 1'b0;
        st_type    = T_NOMEM;
        st_addr    = 32'h0;
        st_data    = 32'h0;
        mem_wr_ack = 1'b0;
        ld_valid   = 1'b0;
        ld_addr    = 32'h0;
    endtask

    task automatic drive_store(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_type  = t;
        st_addr  = a;
        st_data  = d;
    endtask

    // Advances one clock edge and updates the reference model from the
    // inputs that were present at that edge.
    task automatic cycle();
        bit     kind, bad, acc, mis, pop;
        entry_t e, junk;
        kind = st_valid && (st_type == T_SB || st_type == T_SH || st_type == T_SW);
        bad  = (st_type == T_SH && st_addr[0]) || (st_type == T_SW && st_addr[1:0] != 2'b00);
        acc  = !rst && kind && exp_q.size() < DEPTH && !bad;
        mis  = !rst && kind && exp_q.size() < DEPTH && bad;
        pop  = !rst && mem_wr_ack && exp_q.size() > 0;
        e.addr = st_addr & 32'hFFFF_FFFC;
        e.data = st_data;
        e.be   = 4'b1111;
        if (st_type == T_SB) begin
            e.data = {4{st_data[7:0]}};
            e.be   = 4'b0001 << st_addr[1:0];
        end else if (st_type == T_SH) begin
            e.data = {2{st_data[15:0]}};
            e.be   = st_addr[1] ? 4'b1100 : 4'b0011;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            mis_exp = 1'b0;
        end else begin
            if (pop) junk = exp_q.pop_front();
            if (acc) exp_q.push_back(e);
            mis_exp = mis;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        rst = 1'b1;
        ld_valid = 1'b1;
        cycle();
        cycle();
        n_tests++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", mem_wr_en); end
        n_tests++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL reset_st_ready: got %b want 0", st_ready); end
        n_tests++; if (buf_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", buf_empty); end
        n_tests++; if (ld_hit !== 1'b0) begin n_fail++; $display("FAIL reset_ld_hit: got %b want 0", ld_hit); end
        n_tests++; if (st_misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_mis: got %b want 0", st_misaligned); end
        rst = 1'b0;
        idle();
        cycle();
        n_tests++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", st_ready); end
    endtask

    task automatic test_byte_lanes();
        drive_store(T_SB, 32'h0000_1003, 32'h0000_00A5);
        #1;
        n_tests++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL sb_pre_en: got %b want 0", mem_wr_en); end
        cycle();
        idle();
        n_tests++; if (mem_wr_en !== 1'b1) begin n_fail++; $display("FAIL sb_en: got %b want 1", mem_wr_en); end
        n_tests++; if (mem_wr_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL sb_addr: got %h want 00001000", mem_wr_addr); end
        n_tests++; if (mem_wr_data !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL sb_data: got %h want a5a5a5a5", mem_wr_data); end
        n_tests++; if (mem_wr_be !== 4'b1000) begin n_fail++; $display("FAIL sb_be: got %b want 1000", mem_wr_be); end
        mem_wr_ack = 1'b1;
        cycle();
        idle();
        n_tests++; if (buf_empty !== 1'b1) begin n_fail++; $display("FAIL sb_drained: got %b want 1", buf_empty); end
    endtask

    task automatic test_half_word();
        drive_store(T_SH, 32'h0000_2002, 32'h1234_BEEF);
        cycle();
        drive_store(T_SW, 32'h0000_2004, 32'hDEAD_BEEF);
        cycle();
        idle();
        n_tests++; if (mem_wr_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL sh_addr: got %h want 00002000", mem_wr_addr); end
        n_tests++; if (mem_wr_data !== 32'hBEEF_BEEF) begin n_fail++; $display("FAIL sh_data: got %h want beefbeef", mem_wr_data); end
        n_tests++; if (mem_wr_be !== 4'b1100) begin n_fail++; $display("FAIL sh_be: got %b want 1100", mem_wr_be); end
        cycle();
        n_tests++; if (mem_wr_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL sh_hold: got %h want 00002000", mem_wr_addr); end
        mem_wr_ack = 1'b1;
        cycle();
        mem_wr_ack = 1'b0;
        n_tests++; if (mem_wr_addr !== 32'h0000_2004) begin n_fail++; $display("FAIL sw_addr: got %h want 00002004", mem_wr_addr); end
        n_tests++; if (mem_wr_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_data: got %h want deadbeef", mem_wr_data); end
        n_tests++; if (mem_wr_be !== 4'b1111) begin n_fail++; $display("FAIL sw_be: got %b want 1111", mem_wr_be); end
        mem_wr_ack = 1'b1;
        cycle();
        idle();
        n_tests++; if (buf_empty !== 1'b1) begin n_fail++; $display("FAIL sw_drained: got %b want 1", buf_empty); end
    endtask

    task automatic test_misaligned();
        logic [2:0] bad_types[2];
        bad_types[0] = T_SW;
        bad_types[1] = T_SH;
        for (int k = 0; k < 2; k++) begin
            drive_store(bad_types[k], 32'h0000_3001, 32'h1111_2222);
            cycle();
            idle();
            n_tests++; if (st_misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_pulse_%0d: got %b want 1", k, st_misaligned); end
            n_tests++; if (buf_empty !== 1'b1) begin n_fail++; $display("FAIL mis_empty_%0d: got %b want 1", k, buf_empty); end
            cycle();
            n_tests++; if (st_misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_one_cycle_%0d: got %b want 0", k, st_misaligned); end
        end
        drive_store(T_NOMEM, 32'h0000_3001, 32'h0);
        cycle();
        idle();
        n_tests++; if (st_misaligned !== 1'b0 || buf_empty !== 1'b1) begin n_fail++; $display("FAIL nomem: got mis=%b empty=%b want mis=0 empty=1", st_misaligned, buf_empty); end
        drive_store(T_SB, 32'h0000_3001, 32'h0000_0077);
        cycle();
        idle();
        n_tests++; if (st_misaligned !== 1'b0) begin n_fail++; $display("FAIL sb_odd_mis: got %b want 0", st_misaligned); end
        n_tests++; if (mem_wr_be !== 4'b0010 || mem_wr_addr !== 32'h0000_3000) begin n_fail++; $display("FAIL sb_odd: got be=%b addr=%h want be=0010 addr=00003000", mem_wr_be, mem_wr_addr); end
        mem_wr_ack = 1'b1;
        cycle();
        idle();
    endtask

    task automatic test_full();
        drive_store(T_SW, 32'h0000_5000, 32'hAAAA_0000);
        cycle();
        drive_store(T_SW, 32'h0000_5004, 32'hBBBB_0000);
        cycle();
        drive_store(T_SW, 32'h0000_5008, 32'hCCCC_0000);
        #1;
        n_tests++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", st_ready); end
        mem_wr_ack = 1'b1;
        cycle();
        n_tests++; if (mem_wr_addr !== 32'h0000_5004) begin n_fail++; $display("FAIL full_pop_head: got %h want 00005004", mem_wr_addr); end
        n_tests++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL full_no_bypass: got ready=%b want 1 (one left)", st_ready); end
        mem_wr_ack = 1'b0;
        cycle();
        idle();
        n_tests++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL third_accepted: got ready=%b want 0", st_ready); end
        mem_wr_ack = 1'b1;
        cycle();
        n_tests++; if (mem_wr_addr !== 32'h0000_5008 || mem_wr_data !== 32'hCCCC_0000) begin n_fail++; $display("FAIL third_head: got %h/%h want 00005008/cccc0000", mem_wr_addr, mem_wr_data); end
        // push and pop together for several rounds so both pointers wrap
        for (int r = 0; r < 6; r++) begin
            drive_store(T_SW, 32'h0000_5100 + 32'(r * 4), 32'(r));
            mem_wr_ack = 1'b1;
            cycle();
            n_tests++; if (mem_wr_addr !== 32'h0000_5100 + 32'(r * 4)) begin n_fail++; $display("FAIL wrap_%0d: got %h want %h", r, mem_wr_addr, 32'h0000_5100 + 32'(r * 4)); end
        end
        idle();
        mem_wr_ack = 1'b1;
        cycle();
        idle();
        n_tests++; if (buf_empty !== 1'b1) begin n_fail++; $display("FAIL wrap_drained: got %b want 1", buf_empty); end
    endtask

    task automatic test_hazard();
        drive_store(T_SW, 32'h0000_4000, 32'h0);
        cycle();
        idle();
        ld_valid = 1'b1;
        ld_addr  = 32'h0000_4002;
        #1;
        n_tests++; if (ld_hit !== 1'b1) begin n_fail++; $display("FAIL hz_hit: got %b want 1", ld_hit); end
        ld_addr = 32'h0000_4004;
        #1;
        n_tests++; if (ld_hit !== 1'b0) begin n_fail++; $display("FAIL hz_other_word: got %b want 0", ld_hit); end
        ld_addr    = 32'h0000_4002;
        mem_wr_ack = 1'b1;
        cycle();
        mem_wr_ack = 1'b0;
        n_tests++; if (ld_hit !== 1'b0) begin n_fail++; $display("FAIL hz_after_pop: got %b want 0", ld_hit); end
        idle();
    endtask

    task automatic test_reset_mid();
        drive_store(T_SW, 32'h0000_7000, 32'h1);
        cycle();
        drive_store(T_SB, 32'h0000_7005, 32'h2);
        cycle();
        idle();
        rst = 1'b1;
        #1;
        n_tests++; if (mem_wr_en !== 1'b0 || buf_empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_now: got en=%b empty=%b want 0/1", mem_wr_en, buf_empty); end
        cycle();
        rst = 1'b0;
        #1;
        n_tests++; if (st_ready !== 1'b1 || buf_empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_after: got ready=%b empty=%b want 1/1", st_ready, buf_empty); end
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_tests++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale_%0d: got %b want 0", k, mem_wr_en); end
        end
    endtask

    task automatic test_random();
        logic [2:0] types[4];
        bit hit_exp;
        types[0] = T_SB; types[1] = T_SH; types[2] = T_SW; types[3] = T_NOMEM;
        for (int n = 0; n < 400; n++) begin
            st_valid   = ($urandom_range(0, 3) != 0);
            st_type    = types[$urandom_range(0, 3)];
            st_addr    = 32'h0000_6000 + 32'($urandom_range(0, 15));
            st_data    = $urandom;
            mem_wr_ack = ($urandom_range(0, 2) == 0);
            ld_valid   = $urandom_range(0, 1);
            ld_addr    = 32'h0000_6000 + 32'($urandom_range(0, 15));
            #1;
            hit_exp = 1'b0;
            foreach (exp_q[j]) if (exp_q[j].addr[31:2] == ld_addr[31:2]) hit_exp = 1'b1;
            hit_exp = hit_exp && ld_valid;
            n_tests++; if (ld_hit !== hit_exp) begin n_fail++; $display("FAIL rnd_ld_hit[%0d]: got %b want %b", n, ld_hit, hit_exp); end
            n_tests++; if (st_ready !== (exp_q.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, st_ready, exp_q.size() < DEPTH); end
            n_tests++; if (st_misaligned !== mis_exp) begin n_fail++; $display("FAIL rnd_mis[%0d]: got %b want %b", n, st_misaligned, mis_exp); end
            n_tests++; if (mem_wr_en !== (exp_q.size() > 0)) begin n_fail++; $display("FAIL rnd_en[%0d]: got %b want %b", n, mem_wr_en, exp_q.size() > 0); end
            if (exp_q.size() > 0) begin
                n_tests++;
                if ({mem_wr_addr, mem_wr_data, mem_wr_be} !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL rnd_head[%0d]: got %h/%h/%b want %h/%h/%b", n, mem_wr_addr, mem_wr_data, mem_wr_be,
                             exp_q[0].addr, exp_q[0].data, exp_q[0].be);
                end
            end
            cycle();
        end
        idle();
        for (int k = 0; k < DEPTH + 1; k++) begin
            mem_wr_ack = 1'b1;
            cycle();
        end
        idle();
        n_tests++; if (buf_empty !== 1'b1) begin n_fail++; $display("FAIL rnd_drained: got %b want 1", buf_empty); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst = 1'b1;
        mis_exp = 1'b0;
        idle();
        test_reset();
        test_byte_lanes();
        test_half_word();
        test_misaligned();
        test_full();
        test_hazard();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Store-side counterpart of the load data extender: accepts RV32I store requests from the MEM stage, converts them into word-aligned write data plus byte enables, and queues them in a small FIFO that drains to data memory over a request/acknowledge handshake. It sits between the MEM stage and the data memory port. It also flags misaligned stores and reports load-after-store hazards against pending entries so the hazard unit can stall.

## Interface
- DEPTH, 2, number of buffer entries; power of two, ≥2
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- st_valid  input  1  store request present from MEM stage
- st_type  input  3  store kind; `SB`, `SH`, `SW` or `NOMEM` codes from Parameters.vh
- st_addr  input  32  byte address of the store
- st_data  input  32  rs2 value; low byte/halfword used for SB/SH
- st_ready  output  1  buffer can accept a store this cycle
- st_misaligned  output  1  registered one-cycle pulse: the previous request was misaligned and dropped
- mem_wr_en  output  1  head entry valid, write requested
- mem_wr_addr  output  32  head word address, bits [1:0] = 0
- mem_wr_data  output  32  head lane-replicated write data
- mem_wr_be  output  4  head byte enables, bit i = byte i
- mem_wr_ack  input  1  memory accepted head write this cycle
- ld_valid  input  1  load in MEM stage
- ld_addr  input  32  load byte address
- ld_hit  output  1  load word address matches a pending entry
- buf_empty  output  1  no pending entries

## Operation
- Accept: st_valid & st_ready & st_type ≠ `NOMEM` & aligned → enqueue at tail.
- Alignment: SB always aligned; SH misaligned if st_addr[0]=1; SW misaligned if st_addr[1:0]≠0.
- Misaligned request with st_valid & st_ready: not enqueued; st_misaligned=1 in the next cycle only.
- `NOMEM` with st_valid: ignored, no pulse, no enqueue.
- Entry formation:
  - SB: data = {4{st_data[7:0]}}, be = 4'b0001 << st_addr[1:0]
  - SH: data = {2{st_data[15:0]}}, be = st_addr[1] ? 4'b1100 : 4'b0011
  - SW: data = st_data, be = 4'b1111
  - addr = {st_addr[31:2], 2'b00}
- Drain: while count>0, mem_wr_en=1 and mem_wr_* show the head entry. mem_wr_ack with mem_wr_en=1 pops the head. mem_wr_ack with mem_wr_en=0 is ignored.
- Storage: circular FIFO with head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, and a count of 0..DEPTH.
- st_ready = (count < DEPTH) & ~rst. When full, no store is accepted even if a pop happens the same cycle; there is no bypass.
- Simultaneous push and pop when not full: count unchanged and both pointers advance.
- ld_hit = ld_valid & (some valid entry has addr[31:2] == ld_addr[31:2]). The check is combinational and does not depend on byte enables.
- buf_empty = (count == 0).
- Entries are never reordered or merged; memory sees writes in program order.

## Timing
- Reset (rst=1 at an edge): count, pointers and st_misaligned cleared. All pending entries are discarded, including a head awaiting ack. While rst=1: mem_wr_en=0, mem_wr_addr/data/be=0, st_ready=0, ld_hit=0, buf_empty=1.
- Store accepted at edge N → mem_wr_en=1 from cycle N+1 at the earliest (one-cycle latency when empty).
- Head outputs are register-driven from storage; they are stable while mem_wr_en=1 and no ack occurs.
- An ack at edge M makes the next entry visible in cycle M+1. Back-to-back acks drain one entry per cycle.
- ld_hit reflects state after the most recent edge. A store enqueued at edge N is visible to loads from cycle N+1. An entry popped at edge M is not visible from cycle M+1.
- st_misaligned is high exactly one cycle after the offending request's edge.

## Test plan
- Byte lanes: SB st_addr=0x1003, st_data=0xA5 → mem_wr_addr=0x1000, mem_wr_data=0xA5A5A5A5, mem_wr_be=4'b1000, mem_wr_en high one cycle after acceptance.
- Halfword and word: SH 0x2002, data 0x1234BEEF → data 0xBEEFBEEF, be 4'b1100. SW 0x2004, data 0xDEADBEEF → be 4'b1111. Drain order matches issue order.
- Misaligned: SW st_addr=0x3001 → no enqueue, buf_empty stays 1, st_misaligned=1 for exactly one cycle. SH 0x3001 gives the same result. SB 0x3001 is accepted.
- Full/backpressure: with DEPTH=2 and mem_wr_ack held 0, issue 3 stores → first two accepted, st_ready=0. Asserting ack with st_valid in the same cycle does not accept the third store. It is accepted in the next cycle, and pointers wrap correctly over ≥5 push/pop rounds.
- Hazard: pending SW 0x4000, load 0x4002 → ld_hit=1. Load 0x4004 → ld_hit=0. After the ack pop, load 0x4002 → ld_hit=0 from the following cycle.
- Reset mid-operation: two pending entries with the head unacked, assert rst for one cycle → mem_wr_en=0 and buf_empty=1 immediately. After reset, st_ready=1 and no stale write appears on the memory port.
